// File: rtl/lc4_mul_iter.sv
// rtl/lc4_mul_iter.sv - iterative unsigned shift-add multiplier, one multiplier bit per cycle
module lc4_mul_iter #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_multiplicand,
   input  logic [WIDTH-1:0] i_multiplier,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_product_lo,
   output logic [WIDTH-1:0] o_product_hi
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state, state_nx;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] addend;
   logic               accept;

   assign accept = i_valid && (state == IDLE);

   // Partial product is widened before shifting so no high bits are lost.
   always_comb begin
      addend = '0;
      if (mplier[0])
         addend = {{WIDTH{1'b0}}, mcand} << cnt;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_valid) state_nx = BUSY;
         BUSY:    if (cnt == LAST_CNT) state_nx = DONE;
         DONE:    if (i_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         acc    <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            mcand  <= i_multiplicand;
            mplier <= i_multiplier;
            cnt    <= '0;
            acc    <= '0;
         end else if (state == BUSY) begin
            acc    <= acc + addend;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
         end
      end
   end

   // Product outputs track acc directly: partial in BUSY, held in DONE and IDLE.
   assign o_ready      = (state == IDLE);
   assign o_valid      = (state == DONE);
   assign o_product_lo = acc[WIDTH-1:0];
   assign o_product_hi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_lc4_mul_iter.sv
// tb/tb_lc4_mul_iter.sv - directed and random checks of lc4_mul_iter
module tb_lc4_mul_iter;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_multiplicand;
   logic [15:0] i_multiplier;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_product_lo;
   logic [15:0] o_product_hi;

   int errors = 0;
   int checks = 0;

   lc4_mul_iter #(.WIDTH(16), .CNT_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_product_lo   (o_product_lo),
      .o_product_hi   (o_product_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait for the result, hold it `hold` cycles, then take it.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int hold);
      logic [31:0] exp_p;
      int          lat;
      logic        stable;
      exp_p = {16'h0, a} * {16'h0, b};
      check({tag, "_ready_idle"}, {31'h0, o_ready}, 32'd1);
      i_multiplicand = a;
      i_multiplier   = b;
      i_valid        = 1'b1;
      step();
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 32'd16);
      check({tag, "_product"}, {o_product_hi, o_product_lo}, exp_p);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (!o_valid || {o_product_hi, o_product_lo} !== exp_p || o_ready)
            stable = 1'b0;
      end
      check({tag, "_hold_stable"}, {31'h0, stable}, 32'd1);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'h0, o_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'h0, o_ready}, 32'd1);
      check({tag, "_idle_retain"}, {o_product_hi, o_product_lo}, exp_p);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      int          lat;

      rst_n          = 1'b0;
      i_valid        = 1'b0;
      i_ready        = 1'b0;
      i_multiplicand = '0;
      i_multiplier   = '0;
      #1;
      check("rst_o_ready", {31'h0, o_ready}, 32'd1);
      check("rst_o_valid", {31'h0, o_valid}, 32'd0);
      check("rst_product", {o_product_hi, o_product_lo}, 32'h0);
      step();
      step();
      #2 rst_n = 1'b1;
      step();

      // i_ready with no result pending must do nothing
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      check("stray_ready_valid", {31'h0, o_valid}, 32'd0);
      check("stray_ready_ready", {31'h0, o_ready}, 32'd1);

      run_op("mul_3x5", 16'd3, 16'd5, 0);
      run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 0);
      run_op("mul_zero", 16'h0000, 16'h1234, 0);
      run_op("mul_hold10", 16'h00FF, 16'h0101, 10);

      // Operands and i_valid presented during BUSY must be ignored.
      i_multiplicand = 16'h0101;
      i_multiplier   = 16'h0202;
      i_valid        = 1'b1;
      step();
      i_multiplicand = 16'h7777;
      i_multiplier   = 16'h9999;
      for (int i = 0; i < 5; i++) begin
         step();
         check("busy_ready_low", {31'h0, o_ready}, 32'd0);
      end
      i_valid = 1'b0;
      lat = 5;
      while (!o_valid && lat < 40) begin
         step();
         lat++;
      end
      check("busy_ign_latency", lat, 32'd16);
      check("busy_ign_product", {o_product_hi, o_product_lo}, 32'h0002_0402);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;

      // Reset in the middle of an op discards it.
      i_multiplicand = 16'h1234;
      i_multiplier   = 16'h5678;
      i_valid        = 1'b1;
      step();
      i_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'h0, o_valid}, 32'd0);
      check("midrst_ready", {31'h0, o_ready}, 32'd1);
      check("midrst_product", {o_product_hi, o_product_lo}, 32'h0);
      step();
      #2 rst_n = 1'b1;
      run_op("mul_7x9", 16'd7, 16'd9, 0);
      check("mul_7x9_lo", {16'h0, o_product_lo}, 32'h0000_003F);

      for (int n = 0; n < 200; n++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         run_op($sformatf("rand%0d", n), ra, rb, int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
